// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception/interrupt unit: SR, Cause, EPC, PRId and handler entry at M stage.
module cp0_exc_unit #(
    parameter logic [31:0] PRID = 32'h2021_0007,
    parameter int          IM_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     pc_m,
    input  logic            bd_m,
    input  logic [4:0]      exc_code_m,
    input  logic [IM_W-1:0] hw_int,
    input  logic            we,
    input  logic [4:0]      addr,
    input  logic [31:0]     wdata,
    input  logic            eret_m,
    output logic [31:0]     rdata,
    output logic [31:0]     epc_out,
    output logic            req,
    output logic            exl_out
);

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [IM_W-1:0] sr_im;
    logic            sr_exl;
    logic            sr_ie;
    logic            cause_bd;
    logic [IM_W-1:0] cause_ip;
    logic [4:0]      cause_exc;
    logic [31:2]     epc;

    logic        int_req;
    logic        exc_req;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    // Interrupts sample the live lines so a request is taken the same cycle it rises.
    assign int_req   = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_req   = (exc_code_m != 5'd0) & ~sr_exl;
    assign req       = ~reset & (int_req | exc_req);
    assign victim_pc = bd_m ? (pc_m - 32'd4) : pc_m;
    assign epc_out   = {epc, 2'b00};
    assign exl_out   = sr_exl;

    always_comb begin
        sr_val               = '0;
        sr_val[10 +: IM_W]   = sr_im;
        sr_val[1]            = sr_exl;
        sr_val[0]            = sr_ie;
        cause_val            = '0;
        cause_val[31]        = cause_bd;
        cause_val[10 +: IM_W] = cause_ip;
        cause_val[6:2]       = cause_exc;
    end

    always_comb begin
        rdata = '0;
        case (addr)
            A_SR:    rdata = sr_val;
            A_CAUSE: rdata = cause_val;
            A_EPC:   rdata = {epc, 2'b00};
            A_PRID:  rdata = PRID;
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_m;
                cause_exc <= int_req ? 5'd0 : exc_code_m;
                epc       <= victim_pc[31:2];
            end else begin
                if (we && addr == A_SR) begin
                    sr_im  <= wdata[10 +: IM_W];
                    sr_exl <= wdata[1];
                    sr_ie  <= wdata[0];
                end
                if (we && addr == A_EPC)
                    epc <= wdata[31:2];
                // eret is ordered after mtc0 so it always wins on EXL.
                if (eret_m)
                    sr_exl <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - table-driven self-checking bench for cp0_exc_unit.
module tb_cp0_exc_unit;

    logic        clk;
    logic        reset;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic [5:0]  hw_int;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret_m;
    logic [31:0] rdata;
    logic [31:0] epc_out;
    logic        req;
    logic        exl_out;

    int checks = 0;
    int errors = 0;

    cp0_exc_unit #(.PRID(32'h2021_0007), .IM_W(6)) dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m),
        .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata), .eret_m(eret_m),
        .rdata(rdata), .epc_out(epc_out), .req(req), .exl_out(exl_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        eret;
        logic        e_req;
        logic [31:0] e_rdata;
        logic [31:0] e_epc;
        logic        e_exl;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] p, input logic b, input logic [4:0] e, input logic [5:0] h,
                         input logic w, input logic [4:0] a, input logic [31:0] d, input logic er);
        pc_m = p; bd_m = b; exc_code_m = e; hw_int = h;
        we = w; addr = a; wdata = d; eret_m = er;
    endtask

    initial begin
        //                pc          bd    exc    hw     we    addr   wdata         eret  req   rdata         epc           exl
        vecs.push_back('{32'h0,    1'b0, 5'd0,  6'd1, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{32'h0,    1'b0, 5'd0,  6'd1, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h0000_0400, 32'h0,       1'b0});
        vecs.push_back('{32'h0,    1'b0, 5'd0,  6'd1, 1'b0, 5'd15, 32'h0,       1'b0, 1'b0, 32'h2021_0007, 32'h0,       1'b0});
        vecs.push_back('{32'h3010, 1'b0, 5'd0,  6'd1, 1'b1, 5'd12, 32'h401,     1'b0, 1'b0, 32'h0,        32'h0,        1'b0});
        vecs.push_back('{32'h3010, 1'b0, 5'd0,  6'd1, 1'b0, 5'd12, 32'h0,       1'b0, 1'b1, 32'h401,      32'h0,        1'b0});
        vecs.push_back('{32'h3014, 1'b0, 5'd0,  6'd1, 1'b0, 5'd14, 32'h0,       1'b0, 1'b0, 32'h3010,     32'h3010,     1'b1});
        vecs.push_back('{32'h3014, 1'b0, 5'd0,  6'd1, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h0000_0400, 32'h3010,    1'b1});
        vecs.push_back('{32'h3014, 1'b0, 5'd0,  6'd0, 1'b0, 5'd12, 32'h0,       1'b1, 1'b0, 32'h403,      32'h3010,     1'b1});
        vecs.push_back('{32'h3024, 1'b1, 5'd12, 6'd0, 1'b0, 5'd13, 32'h0,       1'b0, 1'b1, 32'h0,        32'h3010,     1'b0});
        vecs.push_back('{32'h3040, 1'b0, 5'd10, 6'd0, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h8000_0030, 32'h3020,    1'b1});
        vecs.push_back('{32'h3040, 1'b0, 5'd0,  6'd0, 1'b0, 5'd14, 32'h0,       1'b1, 1'b0, 32'h3020,     32'h3020,     1'b1});
        vecs.push_back('{32'h3040, 1'b0, 5'd0,  6'd0, 1'b0, 5'd12, 32'h0,       1'b0, 1'b0, 32'h401,      32'h3020,     1'b0});
        vecs.push_back('{32'h3100, 1'b0, 5'd4,  6'd0, 1'b1, 5'd14, 32'h5000,    1'b0, 1'b1, 32'h3020,     32'h3020,     1'b0});
        vecs.push_back('{32'h3104, 1'b0, 5'd0,  6'd0, 1'b0, 5'd14, 32'h0,       1'b0, 1'b0, 32'h3100,     32'h3100,     1'b1});
        vecs.push_back('{32'h3104, 1'b0, 5'd0,  6'd0, 1'b1, 5'd14, 32'h5003,    1'b0, 1'b0, 32'h3100,     32'h3100,     1'b1});
        vecs.push_back('{32'h3104, 1'b0, 5'd0,  6'd0, 1'b0, 5'd14, 32'h0,       1'b0, 1'b0, 32'h5000,     32'h5000,     1'b1});
        vecs.push_back('{32'h3104, 1'b0, 5'd0,  6'd0, 1'b1, 5'd12, 32'h403,     1'b1, 1'b0, 32'h403,      32'h5000,     1'b1});
        vecs.push_back('{32'h3104, 1'b0, 5'd0,  6'd0, 1'b0, 5'd12, 32'h0,       1'b0, 1'b0, 32'h401,      32'h5000,     1'b0});
        vecs.push_back('{32'h3200, 1'b1, 5'd10, 6'd1, 1'b0, 5'd13, 32'h0,       1'b0, 1'b1, 32'h10,       32'h5000,     1'b0});
        vecs.push_back('{32'h3204, 1'b0, 5'd0,  6'd0, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h8000_0400, 32'h31FC,    1'b1});
        vecs.push_back('{32'h3204, 1'b0, 5'd0,  6'd0, 1'b1, 5'd13, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h8000_0000, 32'h31FC,  1'b1});
        vecs.push_back('{32'h3204, 1'b0, 5'd0,  6'd0, 1'b0, 5'd13, 32'h0,       1'b0, 1'b0, 32'h8000_0000, 32'h31FC,    1'b1});
        vecs.push_back('{32'h3204, 1'b0, 5'd0,  6'd0, 1'b1, 5'd7,  32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0,      32'h31FC,     1'b1});
        vecs.push_back('{32'h3204, 1'b0, 5'd0,  6'd0, 1'b0, 5'd12, 32'h0,       1'b0, 1'b0, 32'h403,      32'h31FC,     1'b1});

        reset = 1'b1;
        drive(32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].bd, vecs[i].exc, vecs[i].hw,
                  vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].eret);
            #1;
            check($sformatf("v%0d req", i),     {31'd0, req},     {31'd0, vecs[i].e_req});
            check($sformatf("v%0d rdata", i),   rdata,            vecs[i].e_rdata);
            check($sformatf("v%0d epc_out", i), epc_out,          vecs[i].e_epc);
            check($sformatf("v%0d exl", i),     {31'd0, exl_out}, {31'd0, vecs[i].e_exl});
            @(negedge clk);
        end

        // PC wrap for a delay-slot exception at address 0
        drive(32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        drive(32'h0, 1'b1, 5'd4, 6'd0, 1'b0, 5'd13, 32'h0, 1'b0);
        #1;
        check("wrap req", {31'd0, req}, 32'd1);
        @(negedge clk);
        drive(32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd13, 32'h0, 1'b0);
        #1;
        check("wrap epc_out", epc_out, 32'hFFFF_FFFC);
        check("wrap cause", rdata, 32'h8000_0010);

        // Reset with a pending exception and EXL clear
        drive(32'h0, 1'b0, 5'd0, 6'd0, 1'b0, 5'd0, 32'h0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        drive(32'h4000, 1'b0, 5'd4, 6'd0, 1'b0, 5'd12, 32'h0, 1'b0);
        #1;
        check("rst exl before", {31'd0, exl_out}, 32'd0);
        check("rst req", {31'd0, req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        drive(32'h4000, 1'b0, 5'd0, 6'd0, 1'b0, 5'd12, 32'h0, 1'b0);
        #1;
        check("rst sr", rdata, 32'h0);
        addr = 5'd13;
        #1;
        check("rst cause", rdata, 32'h0);
        addr = 5'd14;
        #1;
        check("rst epc", rdata, 32'h0);
        check("rst epc_out", epc_out, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt unit at the M stage of the 5-stage pipeline; the consumer end of the exception flags carried by the stage registers (ExcCode, branch-delay bit, mtc0 write, eret).
- Holds SR, Cause, EPC and PRId. Decides exception/interrupt entry, records the victim PC, and supplies the handler request and EPC for flushing and redirecting the pipeline.

Parameters:
PRID, 32'h2021_0007, value returned on reads of register 15.
IM_W, 6, number of hardware interrupt lines / IM and IP field width.

Ports:
clk  input  1  clock.
reset  input  1  synchronous, active-high reset.
pc_m  input  32  macroscopic PC of the M-stage instruction; for a bubble, the pipeline supplies the next real PC.
bd_m  input  1  M-stage instruction sits in a branch delay slot.
exc_code_m  input  5  pending exception code from the pipe; 0 means none.
hw_int  input  IM_W  level-sensitive external interrupt lines.
we  input  1  mtc0 write enable.
addr  input  5  CP0 register number for read and write.
wdata  input  32  mtc0 write data.
eret_m  input  1  eret instruction in M.
rdata  output  32  mfc0 read data, combinational.
epc_out  output  32  current EPC for eret redirect.
req  output  1  exception/interrupt taken this cycle; flush pipeline and fetch the handler.
exl_out  output  1  current SR.EXL.

Behaviour:
- Register fields (all other bits read 0):
  - SR(12): IM[15:10], EXL[1], IE[0].
  - Cause(13): BD[31], IP[15:10], ExcCode[6:2].
  - EPC(14): bits [31:2]; bits [1:0] always 0.
  - PRId(15): constant PRID.
- Reset:
  - SR, Cause and EPC clear to 0 at the clock edge with reset high.
  - req is forced to 0 while reset is high.
  - rdata and epc_out reflect the cleared registers from the next cycle on.
- int_req = |(hw_int & SR.IM) & SR.IE & !SR.EXL, using the live hw_int, not the registered IP.
- exc_req = (exc_code_m != 0) & !SR.EXL.
- req = !reset & (int_req | exc_req), combinational, same cycle as the inputs.
- On a clock edge with req=1:
  - SR.EXL <= 1.
  - Cause.BD <= bd_m.
  - Cause.ExcCode <= int_req ? 0 : exc_code_m. Interrupt has priority over a simultaneous exception.
  - EPC <= (bd_m ? pc_m-4 : pc_m) with bits [1:0] cleared.
  - Any concurrent mtc0 write is dropped, and eret_m is ignored.
- Cause.IP <= hw_int on every non-reset edge, regardless of EXL or req.
- eret_m=1 with req=0: SR.EXL <= 0 at the edge. epc_out is valid in the same cycle.
- mtc0 (we=1, req=0):
  - addr 12 writes IM, EXL and IE.
  - addr 14 writes EPC with bits [1:0] cleared.
  - Writes to 13, 15 and all other addresses are ignored.
  - The new value is visible on rdata the cycle after the edge; same-cycle reads return the old value.
- eret and mtc0 SR in the same cycle: the mtc0 value of EXL is written, then eret clears EXL. Net EXL = 0.
- While EXL=1:
  - Exceptions and interrupts are masked; req=0.
  - Only IP updates; BD, ExcCode and EPC hold.
- Address ranges:
  - rdata = 0 for addr outside 12..15.
  - PC arithmetic wraps modulo 2^32; pc_m=0 with bd_m=1 gives EPC=32'hFFFF_FFFC.

Test Plan:
1. Reset, then IE=0, hw_int=6'b000001 -> req=0 and Cause reads 32'h0000_0400; PRId reads 32'h2021_0007.
2. mtc0 SR=32'h0000_0401, hw_int[0]=1, pc_m=32'h0000_3010, bd_m=0 -> req=1 in the same cycle; after the edge, EPC=32'h0000_3010, ExcCode=0, EXL=1, and req drops to 0.
3. exc_code_m=12 (Ov), bd_m=1, pc_m=32'h0000_3024, EXL=0 -> req=1; after the edge, EPC=32'h0000_3020, Cause=32'h8000_0030 with IP=0.
4. exc_code_m=10 while EXL=1 -> req=0 and EPC unchanged. Then eret_m=1 -> EXL=0 next cycle and epc_out equals the stored EPC.
5. Same cycle: we=1, addr=14, wdata=32'h0000_5000, with exc_code_m=4 and pc_m=32'h0000_3100 -> EPC=32'h0000_3100 (exception wins). Next, mtc0 EPC=32'h0000_5003 with no req -> EPC reads 32'h0000_5000.
6. Reset asserted while exc_code_m=4 and EXL=0 -> req=0 during reset; SR, Cause and EPC are all 0 afterwards.
